pvtmon_regbank: RTL

PVTMON_REGBANK -- requirements
Module: pvtmon_regbank

---
 rtl/pvtmon_regbank_pkg.sv | 87 ++++++++
 rtl/pvtmon_minmax.sv | 49 ++++
 rtl/pvtmon_regbank.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pvtmon_regbank_pkg.sv
// Shared constants, word-map offsets and address decode for the PVT monitor register bank.
package pvtmon_regbank_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] MAX_RST_VAL = 32'h0000_0000;
    localparam logic [31:0] MIN_RST_VAL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        WK_LIVE,
        WK_MAX,
        WK_MIN,
        WK_CONST,
        WK_CTRL,
        WK_CLEAR,
        WK_NONE
    } word_kind_e;

    // idx is the position inside the region (channel, control register, or constant slot)
    typedef struct packed {
        word_kind_e kind;
        logic [3:0] idx;
    } word_dec_t;

    function automatic int unsigned off_max(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned off_min(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned off_btime(input int unsigned n);
        return 3 * n;
    endfunction

    function automatic int unsigned off_link(input int unsigned n);
        return 3 * n + 1;
    endfunction

    function automatic int unsigned off_binfo(input int unsigned n);
        return 3 * n + 2;
    endfunction

    function automatic int unsigned off_git(input int unsigned n);
        return 3 * n + 3;
    endfunction

    function automatic int unsigned off_ctrl(input int unsigned n);
        return 3 * n + 4;
    endfunction

    function automatic int unsigned off_clear(input int unsigned n, input int unsigned nc);
        return 3 * n + 4 + nc;
    endfunction

    function automatic int unsigned words_used(input int unsigned n, input int unsigned nc);
        return 3 * n + 5 + nc;
    endfunction

    function automatic word_dec_t decode_word(input int unsigned w, input int unsigned n,
                                              input int unsigned nc);
        word_dec_t d;
        d.kind = WK_NONE;
        d.idx  = '0;
        if (w < off_max(n)) begin
            d.kind = WK_LIVE;
            d.idx  = 4'(w);
        end else if (w < off_min(n)) begin
            d.kind = WK_MAX;
            d.idx  = 4'(w - off_max(n));
        end else if (w < off_btime(n)) begin
            d.kind = WK_MIN;
            d.idx  = 4'(w - off_min(n));
        end else if (w < off_ctrl(n)) begin
            d.kind = WK_CONST;
            d.idx  = 4'(w - off_btime(n));
        end else if (w < off_clear(n, nc)) begin
            d.kind = WK_CTRL;
            d.idx  = 4'(w - off_ctrl(n));
        end else if (w == off_clear(n, nc)) begin
            d.kind = WK_CLEAR;
        end
        return d;
    endfunction

endpackage

// File: rtl/pvtmon_minmax.sv
// One monitored channel: running max/min of qualified samples, restartable by a clear pulse.
module pvtmon_minmax
    import pvtmon_regbank_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] sample_i,
    input  logic        valid_i,
    input  logic        clear_i,
    output logic [31:0] min_o,
    output logic [31:0] max_o
);

    logic [31:0] min_q, min_d;
    logic [31:0] max_q, max_d;

    // A clear coinciding with a sample restarts tracking from that sample rather than losing it
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            if (valid_i) begin
                min_d = sample_i;
                max_d = sample_i;
            end else begin
                min_d = MIN_RST_VAL;
                max_d = MAX_RST_VAL;
            end
        end else if (valid_i) begin
            if (sample_i > max_q) max_d = sample_i;
            if (sample_i < min_q) min_d = sample_i;
        end
    end

    // Extreme-value registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min_q <= MIN_RST_VAL;
            max_q <= MAX_RST_VAL;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;

endmodule

// File: rtl/pvtmon_regbank.sv
// AXI4-Lite register bank exposing live/max/min PVT status, build constants and control registers.
module pvtmon_regbank
    import pvtmon_regbank_pkg::*;
#(
    parameter int          C_S_AXI_ADDR_WIDTH = 8,
    parameter int          NUM_STATUS         = 13,
    parameter int          NUM_CTRL           = 4,
    parameter logic [31:0] BTIME              = 32'h0,
    parameter logic [31:0] BINFO              = 32'h0,
    parameter logic [31:0] GIT_HASH           = 32'h0
) (
    input  logic                                    S_AXI_ACLK,
    input  logic                                    S_AXI_ARESET,
    input  logic [NUM_STATUS*32-1:0]                status,
    input  logic                                    status_valid,
    input  logic                                    pcie_link_up,
    output logic [((NUM_CTRL > 0) ? NUM_CTRL : 1)*32-1:0] ctrl_regs,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic                                    S_AXI_AWVALID,
    output logic                                    S_AXI_AWREADY,
    input  logic [31:0]                             S_AXI_WDATA,
    input  logic [3:0]                              S_AXI_WSTRB,
    input  logic                                    S_AXI_WVALID,
    output logic                                    S_AXI_WREADY,
    output logic [1:0]                              S_AXI_BRESP,
    output logic                                    S_AXI_BVALID,
    input  logic                                    S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
    input  logic                                    S_AXI_ARVALID,
    output logic                                    S_AXI_ARREADY,
    output logic [31:0]                             S_AXI_RDATA,
    output logic [1:0]                              S_AXI_RRESP,
    output logic                                    S_AXI_RVALID,
    input  logic                                    S_AXI_RREADY
);

    localparam int          WORD_W     = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned WORD_SPACE = 32'd1 << WORD_W;
    localparam int          CTRL_N     = (NUM_CTRL > 0) ? NUM_CTRL : 1;

    if (words_used(NUM_STATUS, NUM_CTRL) > WORD_SPACE) begin : g_map_too_big
        $error("pvtmon_regbank: word map does not fit in the AXI address space");
    end
    if (NUM_STATUS < 1 || NUM_STATUS > 16 || NUM_CTRL < 0 || NUM_CTRL > 8) begin : g_bad_counts
        $error("pvtmon_regbank: NUM_STATUS must be 1..16 and NUM_CTRL 0..8");
    end

    // Write channel state
    logic              aw_held_q, aw_held_d;
    logic [WORD_W-1:0] aw_word_q, aw_word_d;
    logic              w_held_q,  w_held_d;
    logic [31:0]       w_data_q,  w_data_d;
    logic [3:0]        w_strb_q,  w_strb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;

    // Read channel state
    logic              rvalid_q,  rvalid_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    logic [31:0]       ctrl_q [CTRL_N];
    logic [31:0]       ctrl_d [CTRL_N];

    logic [31:0]       ch_max [NUM_STATUS];
    logic [31:0]       ch_min [NUM_STATUS];

    word_dec_t         wr_dec;
    word_dec_t         rd_dec;
    logic              wr_exec;
    logic              clear_pulse;
    logic [31:0]       rd_word_data;
    logic [1:0]        rd_word_resp;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Ready flags are forced low while reset is asserted so nothing is accepted mid-reset
    assign S_AXI_AWREADY = ~S_AXI_ARESET & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = ~S_AXI_ARESET & ~w_held_q  & ~bvalid_q;
    assign S_AXI_ARREADY = ~S_AXI_ARESET & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign wr_dec      = decode_word(32'(aw_word_q), NUM_STATUS, NUM_CTRL);
    assign rd_dec      = decode_word(32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]), NUM_STATUS, NUM_CTRL);
    assign wr_exec     = aw_held_q & w_held_q;
    assign clear_pulse = wr_exec & (wr_dec.kind == WK_CLEAR) & w_data_q[0] & w_strb_q[0];

    // Write channel: hold AW and W independently, execute once both are present, then respond
    always_comb begin
        aw_held_d = aw_held_q;
        aw_word_d = aw_word_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_held_d = 1'b1;
            aw_word_d = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (wr_exec) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = ((wr_dec.kind == WK_CTRL) || (wr_dec.kind == WK_CLEAR)) ? RESP_OKAY
                                                                                : RESP_SLVERR;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Control registers: byte-lane merge of the executing write
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_exec && (wr_dec.kind == WK_CTRL)) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (wr_dec.idx == 4'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_q[b]) ctrl_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read word mux, evaluated on the AR address so live status is captured at the handshake
    always_comb begin
        rd_word_data = '0;
        rd_word_resp = RESP_OKAY;
        case (rd_dec.kind)
            WK_LIVE: begin
                for (int i = 0; i < NUM_STATUS; i++) begin
                    if (rd_dec.idx == 4'(i)) rd_word_data = status[i*32 +: 32];
                end
            end
            WK_MAX: begin
                for (int i = 0; i < NUM_STATUS; i++) begin
                    if (rd_dec.idx == 4'(i)) rd_word_data = ch_max[i];
                end
            end
            WK_MIN: begin
                for (int i = 0; i < NUM_STATUS; i++) begin
                    if (rd_dec.idx == 4'(i)) rd_word_data = ch_min[i];
                end
            end
            WK_CONST: begin
                case (rd_dec.idx)
                    4'd0:    rd_word_data = BTIME;
                    4'd1:    rd_word_data = {31'b0, pcie_link_up};
                    4'd2:    rd_word_data = BINFO;
                    default: rd_word_data = GIT_HASH;
                endcase
            end
            WK_CTRL: begin
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (rd_dec.idx == 4'(i)) rd_word_data = ctrl_q[i];
                end
            end
            WK_CLEAR: rd_word_data = '0;
            default:  rd_word_resp = RESP_SLVERR;
        endcase
    end

    // Read channel: register data on the AR handshake, hold until RREADY
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word_data;
            rresp_d  = rd_word_resp;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // All bank state; reset drops any half-finished transaction without a response
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_held_q <= 1'b0;
            aw_word_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < CTRL_N; i++) ctrl_q[i] <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_word_q <= aw_word_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < CTRL_N; i++) ctrl_q[i] <= ctrl_d[i];
        end
    end

    for (genvar gi = 0; gi < CTRL_N; gi++) begin : g_ctrl_out
        assign ctrl_regs[gi*32 +: 32] = ctrl_q[gi];
    end

    for (genvar gi = 0; gi < NUM_STATUS; gi++) begin : g_ch
        pvtmon_minmax u_minmax (
            .clk_i    (S_AXI_ACLK),
            .rst_i    (S_AXI_ARESET),
            .sample_i (status[gi*32 +: 32]),
            .valid_i  (status_valid),
            .clear_i  (clear_pulse),
            .min_o    (ch_min[gi]),
            .max_o    (ch_max[gi])
        );
    end

endmodule
